// File: rtl/arith_unit_if.sv
// Handshake bundle between the arithmetic controller (master) and the arith_unit datapath (slave).
// Carries the micro-operation pulses, memory/panel data and the returned status bits.
interface arith_unit_if #(parameter int WIDTH = 30);
    logic             do_clear_a;
    logic             do_clear_b;
    logic             do_clear_c;
    logic             do_not_a;
    logic             do_not_b;
    logic             do_sum;
    logic             do_and;
    logic             do_set_c_30;
    logic             do_left_shift_b;
    logic             do_left_shift_c;
    logic             do_left_shift_c29;
    logic             do_right_shift_bc;
    logic             do_move_c_to_a;
    logic             do_move_c_to_b;
    logic             do_move_b_to_c;
    logic             do_mem_to_c;
    logic [WIDTH-1:0] mem_read_data;
    logic             do_arr_c;
    logic [WIDTH-1:0] arr_reg_c_data;

    logic             carry_out;
    logic             reg_b0;
    logic             reg_c1;
    logic             reg_c30;
    logic [WIDTH-1:0] write_data_to_mem;
    logic [WIDTH-1:0] reg_a_to_pnl;
    logic [WIDTH:0]   reg_b_to_pnl;
    logic [WIDTH-1:0] reg_c_to_pnl;

    modport master (
        output do_clear_a, do_clear_b, do_clear_c, do_not_a, do_not_b, do_sum, do_and,
               do_set_c_30, do_left_shift_b, do_left_shift_c, do_left_shift_c29,
               do_right_shift_bc, do_move_c_to_a, do_move_c_to_b, do_move_b_to_c,
               do_mem_to_c, mem_read_data, do_arr_c, arr_reg_c_data,
        input  carry_out, reg_b0, reg_c1, reg_c30, write_data_to_mem,
               reg_a_to_pnl, reg_b_to_pnl, reg_c_to_pnl
    );

    modport slave (
        input  do_clear_a, do_clear_b, do_clear_c, do_not_a, do_not_b, do_sum, do_and,
               do_set_c_30, do_left_shift_b, do_left_shift_c, do_left_shift_c29,
               do_right_shift_bc, do_move_c_to_a, do_move_c_to_b, do_move_b_to_c,
               do_mem_to_c, mem_read_data, do_arr_c, arr_reg_c_data,
        output carry_out, reg_b0, reg_c1, reg_c30, write_data_to_mem,
               reg_a_to_pnl, reg_b_to_pnl, reg_c_to_pnl
    );
endinterface

// File: rtl/arith_unit.sv
// Magnitude datapath with working registers A[1:30], B[0:30], C[1:30].
// Bit 1 is the MSB (machine numbering); B0 is the overflow position above B1.
module arith_unit #(
    parameter int WIDTH = 30
) (
    input  logic         clk,
    input  logic         resetn,
    arith_unit_if.slave  bus
);

    logic [1:WIDTH] reg_a, a_nxt;
    logic [0:WIDTH] reg_b, b_nxt;
    logic [1:WIDTH] reg_c, c_nxt;

    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum_eac;
    logic             c30_fill;

    // End-around carry: the adder's carry out is folded back into the LSB.
    assign sum_full = {1'b0, reg_a} + {1'b0, reg_b[1:WIDTH]};
    assign sum_eac  = sum_full[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, sum_full[WIDTH]};
    assign c30_fill = (bus.do_left_shift_c29 & reg_c[1]) | bus.do_set_c_30;

    always_comb begin
        a_nxt = reg_a;
        if (bus.do_clear_a)          a_nxt = '0;
        else if (bus.do_move_c_to_a) a_nxt = reg_c;
        else if (bus.do_not_a)       a_nxt = ~reg_a;
    end

    always_comb begin
        b_nxt = reg_b;
        if (bus.do_clear_b)             b_nxt = '0;
        else if (bus.do_move_c_to_b)    b_nxt = {1'b0, reg_c};
        else if (bus.do_sum)            b_nxt = {sum_full[WIDTH], sum_eac};
        else if (bus.do_not_b)          b_nxt = {reg_b[0], ~reg_b[1:WIDTH]};
        else if (bus.do_left_shift_b)   b_nxt = {reg_b[1:WIDTH], 1'b0};
        else if (bus.do_right_shift_bc) b_nxt = {1'b0, reg_b[0:WIDTH-1]};
    end

    // set_c_30 is lowest priority except alongside left_shift_c, where it fills C30.
    always_comb begin
        c_nxt = reg_c;
        if (bus.do_clear_c)             c_nxt = '0;
        else if (bus.do_move_b_to_c)    c_nxt = reg_b[1:WIDTH];
        else if (bus.do_mem_to_c)       c_nxt = bus.mem_read_data;
        else if (bus.do_arr_c)          c_nxt = bus.arr_reg_c_data;
        else if (bus.do_and)            c_nxt = reg_a & reg_c;
        else if (bus.do_left_shift_c)   c_nxt = {reg_c[2:WIDTH], c30_fill};
        else if (bus.do_right_shift_bc) c_nxt = {reg_b[WIDTH], reg_c[1:WIDTH-1]};
        else if (bus.do_set_c_30)       c_nxt[WIDTH] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            reg_a <= '0;
            reg_b <= '0;
            reg_c <= '0;
        end else begin
            reg_a <= a_nxt;
            reg_b <= b_nxt;
            reg_c <= c_nxt;
        end
    end

    assign bus.carry_out         = sum_full[WIDTH];
    assign bus.reg_b0            = reg_b[0];
    assign bus.reg_c1            = reg_c[1];
    assign bus.reg_c30           = reg_c[WIDTH];
    assign bus.write_data_to_mem = reg_c;
    assign bus.reg_a_to_pnl      = reg_a;
    assign bus.reg_b_to_pnl      = reg_b;
    assign bus.reg_c_to_pnl      = reg_c;

endmodule

// File: tb/tb_arith_unit.sv
// Directed self-checking bench for arith_unit: reset, add with end-around carry,
// multiply step, rotate, swap, priority cases and mid-sequence reset.
module tb_arith_unit;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    arith_unit_if #(.WIDTH(30)) bus ();

    arith_unit #(.WIDTH(30)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.do_clear_a        = 1'b0;
        bus.do_clear_b        = 1'b0;
        bus.do_clear_c        = 1'b0;
        bus.do_not_a          = 1'b0;
        bus.do_not_b          = 1'b0;
        bus.do_sum            = 1'b0;
        bus.do_and            = 1'b0;
        bus.do_set_c_30       = 1'b0;
        bus.do_left_shift_b   = 1'b0;
        bus.do_left_shift_c   = 1'b0;
        bus.do_left_shift_c29 = 1'b0;
        bus.do_right_shift_bc = 1'b0;
        bus.do_move_c_to_a    = 1'b0;
        bus.do_move_c_to_b    = 1'b0;
        bus.do_move_b_to_c    = 1'b0;
        bus.do_mem_to_c       = 1'b0;
        bus.do_arr_c          = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_c(input logic [29:0] v);
        bus.mem_read_data = v;
        bus.do_mem_to_c   = 1'b1;
        tick();
        idle();
    endtask

    task automatic set_a(input logic [29:0] v);
        load_c(v);
        bus.do_move_c_to_a = 1'b1;
        tick();
        idle();
    endtask

    task automatic set_b(input logic [29:0] v);
        load_c(v);
        bus.do_move_c_to_b = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        checks++;
        if (bus.reg_a_to_pnl !== 30'h0) begin
            errors++; $display("FAIL reset_a: got %h want %h", bus.reg_a_to_pnl, 30'h0);
        end
        checks++;
        if (bus.reg_b_to_pnl !== 31'h0) begin
            errors++; $display("FAIL reset_b: got %h want %h", bus.reg_b_to_pnl, 31'h0);
        end
        checks++;
        if (bus.reg_c_to_pnl !== 30'h0 || bus.write_data_to_mem !== 30'h0) begin
            errors++; $display("FAIL reset_c: got %h/%h want 0", bus.reg_c_to_pnl, bus.write_data_to_mem);
        end
        checks++;
        if ({bus.carry_out, bus.reg_b0, bus.reg_c1, bus.reg_c30} !== 4'b0000) begin
            errors++; $display("FAIL reset_status: got %b want 0000",
                               {bus.carry_out, bus.reg_b0, bus.reg_c1, bus.reg_c30});
        end
    endtask

    task automatic test_sum_basic();
        set_a(30'd5);
        set_b(30'd3);
        checks++;
        if (bus.carry_out !== 1'b0) begin
            errors++; $display("FAIL sum_basic_carry: got %b want 0", bus.carry_out);
        end
        bus.do_sum = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.reg_b_to_pnl !== 31'd8) begin
            errors++; $display("FAIL sum_basic_b: got %h want %h", bus.reg_b_to_pnl, 31'd8);
        end
    endtask

    task automatic test_end_around();
        set_a(30'h3FFFFFFF);
        set_b(30'h00000002);
        checks++;
        if (bus.carry_out !== 1'b1) begin
            errors++; $display("FAIL eac_carry: got %b want 1", bus.carry_out);
        end
        bus.do_sum = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.reg_b_to_pnl !== 31'h40000002 || bus.reg_b0 !== 1'b1) begin
            errors++; $display("FAIL eac_b: got %h b0 %b want %h b0 1",
                               bus.reg_b_to_pnl, bus.reg_b0, 31'h40000002);
        end
        set_b(30'h3FFFFFFF);
        bus.do_sum = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.reg_b_to_pnl !== 31'h7FFFFFFF) begin
            errors++; $display("FAIL all_ones_sum: got %h want %h", bus.reg_b_to_pnl, 31'h7FFFFFFF);
        end
    endtask

    task automatic test_multiply_step();
        set_a(30'd7);
        bus.do_clear_b = 1'b1;
        tick();
        idle();
        load_c(30'd1);
        checks++;
        if (bus.reg_c30 !== 1'b1) begin
            errors++; $display("FAIL mul_c30: got %b want 1", bus.reg_c30);
        end
        bus.do_sum = bus.reg_c30;
        tick();
        idle();
        bus.do_right_shift_bc = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.reg_b_to_pnl !== 31'd3) begin
            errors++; $display("FAIL mul_b: got %h want %h", bus.reg_b_to_pnl, 31'd3);
        end
        checks++;
        if (bus.reg_c_to_pnl !== 30'h20000000 || bus.reg_c1 !== 1'b1) begin
            errors++; $display("FAIL mul_c: got %h c1 %b want %h c1 1",
                               bus.reg_c_to_pnl, bus.reg_c1, 30'h20000000);
        end
    endtask

    task automatic test_rotate();
        logic [29:0] exp_c [3];
        exp_c[0] = 30'h00000003;
        exp_c[1] = 30'h00000006;
        exp_c[2] = 30'h0000000C;
        load_c(30'h20000001);
        checks++;
        if (bus.reg_c1 !== 1'b1) begin
            errors++; $display("FAIL rot_c1_start: got %b want 1", bus.reg_c1);
        end
        bus.do_left_shift_c   = 1'b1;
        bus.do_left_shift_c29 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.reg_c_to_pnl !== exp_c[i] || bus.reg_c1 !== 1'b0) begin
                errors++; $display("FAIL rot_step%0d: got %h c1 %b want %h c1 0",
                                   i, bus.reg_c_to_pnl, bus.reg_c1, exp_c[i]);
            end
        end
        idle();
        bus.do_left_shift_c29 = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.reg_c_to_pnl !== 30'h0000000C) begin
            errors++; $display("FAIL c29_alone: got %h want %h", bus.reg_c_to_pnl, 30'h0000000C);
        end
    endtask

    task automatic test_swap_and_clear();
        set_b(30'h0AAAAAAA);
        load_c(30'h15555555);
        bus.do_move_c_to_b = 1'b1;
        bus.do_move_b_to_c = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.reg_b_to_pnl !== 31'h15555555 || bus.reg_c_to_pnl !== 30'h0AAAAAAA) begin
            errors++; $display("FAIL swap: got b %h c %h want b %h c %h",
                               bus.reg_b_to_pnl, bus.reg_c_to_pnl, 31'h15555555, 30'h0AAAAAAA);
        end
        set_a(30'h3FFFFFFF);
        bus.do_clear_b = 1'b1;
        bus.do_sum     = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.reg_b_to_pnl !== 31'h0) begin
            errors++; $display("FAIL clear_over_sum: got %h want 0", bus.reg_b_to_pnl);
        end
    endtask

    task automatic test_misc_ops();
        set_b(30'h0AAAAAAA);
        bus.do_not_b = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.reg_b_to_pnl !== 31'h35555555) begin
            errors++; $display("FAIL not_b: got %h want %h", bus.reg_b_to_pnl, 31'h35555555);
        end
        bus.do_left_shift_b = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.reg_b_to_pnl !== 31'h6AAAAAAA) begin
            errors++; $display("FAIL lshift_b: got %h want %h", bus.reg_b_to_pnl, 31'h6AAAAAAA);
        end
        set_a(30'h0F0F0F0F);
        bus.do_not_a = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.reg_a_to_pnl !== 30'h30F0F0F0) begin
            errors++; $display("FAIL not_a: got %h want %h", bus.reg_a_to_pnl, 30'h30F0F0F0);
        end
        load_c(30'h3FFF0000);
        bus.do_and = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.reg_c_to_pnl !== 30'h30F00000) begin
            errors++; $display("FAIL and: got %h want %h", bus.reg_c_to_pnl, 30'h30F00000);
        end
        bus.arr_reg_c_data = 30'h01234567;
        bus.do_arr_c       = 1'b1;
        bus.do_and         = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.reg_c_to_pnl !== 30'h01234567) begin
            errors++; $display("FAIL arr_over_and: got %h want %h", bus.reg_c_to_pnl, 30'h01234567);
        end
        bus.do_left_shift_c = 1'b1;
        bus.do_set_c_30     = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.reg_c_to_pnl !== 30'h02468ACF) begin
            errors++; $display("FAIL shift_set_c30: got %h want %h", bus.reg_c_to_pnl, 30'h02468ACF);
        end
    endtask

    task automatic test_mid_reset();
        set_a(30'h00000055);
        set_b(30'h3FFFFFFF);
        load_c(30'h12345678 & 30'h3FFFFFFF);
        checks++;
        if (bus.write_data_to_mem !== 30'h12345678) begin
            errors++; $display("FAIL mem_load: got %h want %h", bus.write_data_to_mem, 30'h12345678);
        end
        resetn          = 1'b0;
        bus.do_sum      = 1'b1;
        bus.do_mem_to_c = 1'b1;
        tick();
        idle();
        resetn = 1'b1;
        checks++;
        if (bus.reg_a_to_pnl !== 30'h0 || bus.reg_b_to_pnl !== 31'h0 || bus.reg_c_to_pnl !== 30'h0) begin
            errors++; $display("FAIL mid_reset_regs: got a %h b %h c %h want 0",
                               bus.reg_a_to_pnl, bus.reg_b_to_pnl, bus.reg_c_to_pnl);
        end
        checks++;
        if ({bus.carry_out, bus.reg_b0, bus.reg_c1, bus.reg_c30} !== 4'b0000 ||
            bus.write_data_to_mem !== 30'h0) begin
            errors++; $display("FAIL mid_reset_status: got %b wd %h want 0000 wd 0",
                               {bus.carry_out, bus.reg_b0, bus.reg_c1, bus.reg_c30},
                               bus.write_data_to_mem);
        end
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        resetn             = 1'b0;
        bus.mem_read_data  = '0;
        bus.arr_reg_c_data = '0;
        idle();
        test_reset();
        test_sum_basic();
        test_end_around();
        test_multiply_step();
        test_rotate();
        test_swap_and_clear();
        test_misc_ops();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
